// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter and its step datapath.
// Holds the operation mode encodings, the controller state encodings and a
// helper that tells whether a mode leaves the operand unchanged.
package shift_pkg;

    typedef logic [2:0] sh_mode_t;

    // Encodings 000/001/010 line up with the older 2-bit shift type field.
    localparam sh_mode_t SH_SRL = 3'b000;
    localparam sh_mode_t SH_SLL = 3'b001;
    localparam sh_mode_t SH_SRA = 3'b010;
    localparam sh_mode_t SH_ROR = 3'b011;
    localparam sh_mode_t SH_ROL = 3'b100;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // 101..111 are reserved and simply hand the operand through.
    function automatic logic is_pass(input sh_mode_t mode);
        return (mode > SH_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step.
// Ports:
//   work_i : current operand value
//   amt_i  : positions to move this step, 0..STEP
//   mode_i : operation mode (shift_pkg encodings)
//   work_o : operand after the step
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    localparam int AW  = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] work_i,
    input  logic [AW-1:0]   amt_i,
    input  sh_mode_t        mode_i,
    output logic [XLEN-1:0] work_o
);

    always_comb begin
        work_o = work_i;
        case (mode_i)
            SH_SRL: work_o = work_i >> amt_i;
            SH_SLL: work_o = work_i << amt_i;
            // Repeated arithmetic steps compose into one arithmetic shift.
            SH_SRA: work_o = $signed(work_i) >>> amt_i;
            // amt_i never reaches XLEN; amt_i == 0 makes the wide shift
            // yield zero, so the OR still returns work_i unchanged.
            SH_ROR: work_o = (work_i >> amt_i) | (work_i << (XLEN - int'(amt_i)));
            SH_ROL: work_o = (work_i << amt_i) | (work_i >> (XLEN - int'(amt_i)));
            default: work_o = work_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shifter: moves the operand at most STEP positions per clock.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake; ready only while idle
//   in_a, in_shamt      : operand and shift amount
//   in_type             : mode (SRL, SLL, SRA, ROR, ROL, 101..111 pass)
//   out_valid/out_ready : result handshake; result held until taken
//   out_r               : working register; only meaningful with out_valid
//   busy                : operation in flight or result waiting
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(XLEN),
    localparam int AW   = $clog2(STEP + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [SHW-1:0]  in_shamt,
    input  logic [2:0]      in_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_r,
    output logic            busy
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] work_q,  work_d;
    logic [SHW-1:0]  rem_q,   rem_d;
    sh_mode_t        mode_q,  mode_d;

    logic [AW-1:0]   amt;
    logic [XLEN-1:0] step_work;
    logic [SHW:0]    rem_left;

    // Compare one bit wider so STEP == XLEN still fits.
    always_comb begin
        if ({1'b0, rem_q} >= (SHW+1)'(STEP)) amt = AW'(STEP);
        else                                 amt = AW'(rem_q);
    end

    assign rem_left = {1'b0, rem_q} - (SHW+1)'(amt);

    shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
        .work_i (work_q),
        .amt_i  (amt),
        .mode_i (mode_q),
        .work_o (step_work)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d  = in_a;
                    rem_d   = in_shamt;
                    mode_d  = in_type;
                    state_d = (in_shamt == '0 || is_pass(in_type)) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d = step_work;
                rem_d  = rem_left[SHW-1:0];
                if (rem_left == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= SH_SRL;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_r     = work_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
module tb_shift_unit_iter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    // STEP=4 instance
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_a, out_r;
    logic [4:0]  in_shamt;
    logic [2:0]  in_type;
    // STEP=1 instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [31:0] in_a1, out_r1;
    logic [4:0]  in_shamt1;
    logic [2:0]  in_type1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.XLEN(32), .STEP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_shamt(in_shamt), .in_type(in_type),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .busy(busy)
    );

    shift_unit_iter #(.XLEN(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_shamt(in_shamt1), .in_type(in_type1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_r(out_r1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the STEP=4 unit; lat counts cycles from the
    // accept edge until out_valid is seen (1 = visible right after accept).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                          input logic [2:0] t, output int lat);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        in_a = a; in_shamt = sh; in_type = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int  lat;
    logic stable, seen;

    initial begin
        rst = 1'b1; out_ready = 1'b1; out_ready1 = 1'b1;
        in_valid = 0; in_a = 0; in_shamt = 0; in_type = 0;
        in_valid1 = 0; in_a1 = 0; in_shamt1 = 0; in_type1 = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_r", out_r, 32'h0);
        chk("rst_busy", busy, 1'b0);

        // 1: SRL worst case
        run_op("srl31", 32'h8000_0000, 5'd31, SH_SRL, lat);
        chk("srl31_lat", lat, 9);
        chk("srl31_r", out_r, 32'h0000_0001);
        chk("srl31_busy", busy, 1'b1);
        tick();
        chk("srl31_pulse", out_valid, 1'b0);

        // 2: SRA
        run_op("sra4", 32'h8000_0000, 5'd4, SH_SRA, lat);
        chk("sra4_lat", lat, 2);
        chk("sra4_r", out_r, 32'hF800_0000);
        tick();

        // 2b: SRA on STEP=1 unit
        chk("sra5s1_in_ready", in_ready1, 1'b1);
        in_a1 = 32'h8000_0000; in_shamt1 = 5'd5; in_type1 = SH_SRA; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 40) begin tick(); lat++; end
        chk("sra5s1_lat", lat, 6);
        chk("sra5s1_r", out_r1, 32'hFC00_0000);
        tick();

        // 3: rotates
        run_op("rol1", 32'h8000_0001, 5'd1, SH_ROL, lat);
        chk("rol1_lat", lat, 2);
        chk("rol1_r", out_r, 32'h0000_0003);
        tick();
        run_op("ror1", 32'h8000_0001, 5'd1, SH_ROR, lat);
        chk("ror1_r", out_r, 32'hC000_0000);
        tick();
        run_op("ror31", 32'h8000_0001, 5'd31, SH_ROR, lat);
        chk("ror31_lat", lat, 9);
        chk("ror31_r", out_r, 32'h0000_0003);
        tick();

        // Extra patterns: SLL multi-step, SRA with positive operand
        run_op("sll9", 32'h1234_5678, 5'd9, SH_SLL, lat);
        chk("sll9_lat", lat, 4);
        chk("sll9_r", out_r, 32'h68AC_F000);
        tick();
        run_op("sra7", 32'h7F00_0000, 5'd7, SH_SRA, lat);
        chk("sra7_r", out_r, 32'h00FE_0000);
        tick();

        // 4: zero shift and pass-through
        run_op("sll0", 32'h1234_5678, 5'd0, SH_SLL, lat);
        chk("sll0_lat", lat, 1);
        chk("sll0_r", out_r, 32'h1234_5678);
        tick();
        run_op("pass", 32'h1234_5678, 5'd17, 3'b111, lat);
        chk("pass_lat", lat, 1);
        chk("pass_r", out_r, 32'h1234_5678);
        tick();

        // 5: backpressure
        out_ready = 1'b0;
        run_op("bp", 32'hF000_000F, 5'd4, SH_SRL, lat);
        chk("bp_lat", lat, 2);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 32'hDEAD_BEEF; in_shamt = 5'd3; in_type = SH_SLL;
            in_valid = (i % 2 == 0);
            tick();
            if (!out_valid || out_r !== 32'h0F00_0000 || in_ready || !busy) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_stable", stable, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready", in_ready, 1'b1);
        chk("bp_out_valid_drop", out_valid, 1'b0);
        run_op("bp2", 32'h0000_00F0, 5'd6, SH_SLL, lat);
        chk("bp2_lat", lat, 3);
        chk("bp2_r", out_r, 32'h0000_3C00);
        tick();

        // 6: reset in the third SHIFT cycle
        chk("rstmid_in_ready", in_ready, 1'b1);
        in_a = 32'h8000_0000; in_shamt = 5'd31; in_type = SH_SRL; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("rstmid_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_in_ready_after", in_ready, 1'b1);
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_out_r", out_r, 32'h0);
        chk("rstmid_busy", busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("rstmid_no_stale", seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
